// File: rtl/approx_adder_error_monitor.sv
// approx_adder_error_monitor
// On-chip error checker for an approximate adder under test. Samples arrive
// over a valid/ready interface; the exact sum is recomputed internally and
// error statistics are accumulated for ER / MED / MRED / NMED derivation.
//
// Optional build macro: APPROX_MON_COUT_CHECK_EN
//   Adds co_err_count, counting samples whose carry-out differs from the
//   exact carry (x+y)[N]. Without it s_cout is unused.
//
// state | meaning
// IDLE  | waiting for start, no run active
// RUN   | accepting samples until target reached
// DRAIN | no more samples accepted, pipeline emptying
// DONE  | results stable, start re-arms a new run

module approx_adder_error_monitor #(
    parameter int N     = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [N-1:0]     s_x,
    input  logic [N-1:0]     s_y,
    input  logic [N-1:0]     s_sum,
    input  logic             s_cout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_ed,
    output logic [N-1:0]     max_ed,
`ifdef APPROX_MON_COUT_CHECK_EN
    output logic [CNT_W-1:0] co_err_count,
`endif
    output logic [CNT_W-1:0] zero_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] accepted_q;

    logic             s1_valid_q;
    logic [N-1:0]     s1_x_q, s1_y_q, s1_sum_q;
    logic             s1_cout_q;

    logic             s2_valid_q;
    logic [N-1:0]     s2_ed_q;
    logic             s2_zero_q;
    logic             s2_co_mis_q;

    logic [CNT_W-1:0] sample_count_q, err_count_q, zero_count_q, co_err_count_q;
    logic [ACC_W-1:0] sum_ed_q;
    logic [N-1:0]     max_ed_q;

    logic             hs;
    logic             start_clr;
    logic             last_hs;
    logic [N:0]       exact_full;
    logic [N-1:0]     exact;
    logic [N-1:0]     ed;
    logic             co_mis;
    logic [ACC_W:0]   sum_ed_ext;

    // start only counts when no run is active; a pulse while busy is dropped
    assign start_clr  = start && ((state_q == IDLE) || (state_q == DONE));
    assign hs         = s_valid && s_ready;
    assign last_hs    = hs && ((accepted_q + CNT_W'(1)) == target_q);

    // stage-2 arithmetic on stage-1 registers
    assign exact_full = {1'b0, s1_x_q} + {1'b0, s1_y_q};
    assign exact      = exact_full[N-1:0];
    assign ed         = (s1_sum_q >= exact) ? (s1_sum_q - exact) : (exact - s1_sum_q);
    assign co_mis     = s1_cout_q ^ exact_full[N];
    assign sum_ed_ext = {1'b0, sum_ed_q} + {{(ACC_W+1-N){1'b0}}, s2_ed_q};

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) state_d = (num_samples == '0) ? DONE : RUN;
            end
            RUN: begin
                if (last_hs) state_d = DRAIN;
            end
            DRAIN: begin
                if (!s1_valid_q && !s2_valid_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            RUN:     begin s_ready = (accepted_q < target_q); busy = 1'b1; end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // run target and accepted-sample counter
    always_ff @(posedge clk) begin
        if (rst) begin
            target_q   <= '0;
            accepted_q <= '0;
        end else if (start_clr) begin
            target_q   <= num_samples;
            accepted_q <= '0;
        end else if (hs) begin
            accepted_q <= accepted_q + CNT_W'(1);
        end
    end

    // stage 1: capture the handshaken sample
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_sum_q   <= '0;
            s1_cout_q  <= 1'b0;
        end else begin
            s1_valid_q <= hs;
            if (hs) begin
                s1_x_q    <= s_x;
                s1_y_q    <= s_y;
                s1_sum_q  <= s_sum;
                s1_cout_q <= s_cout;
            end
        end
    end

    // stage 2: register error distance and per-sample flags
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q  <= 1'b0;
            s2_ed_q     <= '0;
            s2_zero_q   <= 1'b0;
            s2_co_mis_q <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_ed_q     <= ed;
                s2_zero_q   <= (exact == '0);
                s2_co_mis_q <= co_mis;
            end
        end
    end

    // accumulators, cleared at the start of each run
    always_ff @(posedge clk) begin
        if (rst || start_clr) begin
            sample_count_q <= '0;
            err_count_q    <= '0;
            zero_count_q   <= '0;
            co_err_count_q <= '0;
            sum_ed_q       <= '0;
            max_ed_q       <= '0;
        end else if (s2_valid_q) begin
            sample_count_q <= sample_count_q + CNT_W'(1);
            if (s2_ed_q != '0) err_count_q <= err_count_q + CNT_W'(1);
            if (s2_zero_q)     zero_count_q <= zero_count_q + CNT_W'(1);
            if (s2_co_mis_q)   co_err_count_q <= co_err_count_q + CNT_W'(1);
            sum_ed_q <= sum_ed_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ed_ext[ACC_W-1:0];
            if (s2_ed_q > max_ed_q) max_ed_q <= s2_ed_q;
        end
    end

    assign sample_count = sample_count_q;
    assign err_count    = err_count_q;
    assign zero_count   = zero_count_q;
    assign sum_ed       = sum_ed_q;
    assign max_ed       = max_ed_q;

`ifdef APPROX_MON_COUT_CHECK_EN
    assign co_err_count = co_err_count_q;
`else
    // carry tracking is built but has no observer in this configuration
    logic unused_cout;
    assign unused_cout = ^co_err_count_q;
`endif

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Self-checking bench for approx_adder_error_monitor.
module tb_approx_adder_error_monitor;

    localparam int N     = 16;
    localparam int CNT_W = 32;
    localparam int ACC_W = 48;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             s_valid;
    logic             s_ready;
    logic [N-1:0]     s_x, s_y, s_sum;
    logic             s_cout;
    logic             busy, done;
    logic [CNT_W-1:0] sample_count, err_count, zero_count;
    logic [ACC_W-1:0] sum_ed;
    logic [N-1:0]     max_ed;
`ifdef APPROX_MON_COUT_CHECK_EN
    logic [CNT_W-1:0] co_err_count;
`endif

    always #5 clk = ~clk;

    approx_adder_error_monitor #(.N(N), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_samples  (num_samples),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_x          (s_x),
        .s_y          (s_y),
        .s_sum        (s_sum),
        .s_cout       (s_cout),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count),
        .err_count    (err_count),
        .sum_ed       (sum_ed),
        .max_ed       (max_ed),
`ifdef APPROX_MON_COUT_CHECK_EN
        .co_err_count (co_err_count),
`endif
        .zero_count   (zero_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string           name;
        int              n;
        logic [2:0][15:0] xs;
        logic [2:0][15:0] ys;
        logic [2:0][15:0] ss;
        logic [2:0]      cs;
        int              e_err;
        logic [63:0]     e_sum;
        int              e_max;
        int              e_zero;
        int              e_co;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int n);
        start       = 1'b1;
        num_samples = CNT_W'(n);
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] s, input logic c);
        int k = 0;
        s_x = x; s_y = y; s_sum = s; s_cout = c; s_valid = 1'b1;
        while (!s_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("send_ready_timeout", 64'(s_ready), 64'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(done), 64'd1);
    endtask

    task automatic chk_results(input string tag, input int sc, input int er,
                               input logic [63:0] se, input int mx, input int zc, input int co);
        chk({tag, "_sample_count"}, 64'(sample_count), 64'(sc));
        chk({tag, "_err_count"},    64'(err_count),    64'(er));
        chk({tag, "_sum_ed"},       64'(sum_ed),       se);
        chk({tag, "_max_ed"},       64'(max_ed),       64'(mx));
        chk({tag, "_zero_count"},   64'(zero_count),   64'(zc));
`ifdef APPROX_MON_COUT_CHECK_EN
        chk({tag, "_co_err_count"}, 64'(co_err_count), 64'(co));
`else
        if (co < 0) chk({tag, "_co_arg"}, 64'(co), 64'd0);
`endif
    endtask

    initial begin
        // exact sample
        vecs[0].name = "exact"; vecs[0].n = 1;
        vecs[0].xs = {16'h0, 16'h0, 16'h00FF};
        vecs[0].ys = {16'h0, 16'h0, 16'h0001};
        vecs[0].ss = {16'h0, 16'h0, 16'h0100};
        vecs[0].cs = 3'b000;
        vecs[0].e_err = 0; vecs[0].e_sum = 64'd0; vecs[0].e_max = 0; vecs[0].e_zero = 0; vecs[0].e_co = 0;
        // mixed: ed 4, 0 (exact 0, carry 1 vs cout 0), 5
        vecs[1].name = "mixed"; vecs[1].n = 3;
        vecs[1].xs = {16'h0010, 16'hFFFF, 16'h1000};
        vecs[1].ys = {16'h0010, 16'h0001, 16'h0234};
        vecs[1].ss = {16'h0025, 16'h0000, 16'h1230};
        vecs[1].cs = 3'b000;
        vecs[1].e_err = 2; vecs[1].e_sum = 64'd9; vecs[1].e_max = 5; vecs[1].e_zero = 1; vecs[1].e_co = 1;
        // wrap-around: exact 0, ed 0xFFFF, carry 1 vs cout 0
        vecs[2].name = "wrap"; vecs[2].n = 1;
        vecs[2].xs = {16'h0, 16'h0, 16'h8000};
        vecs[2].ys = {16'h0, 16'h0, 16'h8000};
        vecs[2].ss = {16'h0, 16'h0, 16'hFFFF};
        vecs[2].cs = 3'b000;
        vecs[2].e_err = 1; vecs[2].e_sum = 64'hFFFF; vecs[2].e_max = 16'hFFFF; vecs[2].e_zero = 1; vecs[2].e_co = 1;
        // exact sums, spurious carry on first, zero operands on second
        vecs[3].name = "cout"; vecs[3].n = 2;
        vecs[3].xs = {16'h0, 16'h0000, 16'h0001};
        vecs[3].ys = {16'h0, 16'h0000, 16'h0002};
        vecs[3].ss = {16'h0, 16'h0000, 16'h0003};
        vecs[3].cs = 3'b001;
        vecs[3].e_err = 0; vecs[3].e_sum = 64'd0; vecs[3].e_max = 0; vecs[3].e_zero = 1; vecs[3].e_co = 1;

        rst = 1'b1; start = 1'b0; num_samples = '0; s_valid = 1'b0;
        s_x = '0; s_y = '0; s_sum = '0; s_cout = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_s_ready", 64'(s_ready), 64'd0);
        chk("reset_busy",    64'(busy),    64'd0);
        chk("reset_done",    64'(done),    64'd0);
        chk_results("reset", 0, 0, 64'd0, 0, 0, 0);

        // table-driven runs
        for (int v = 0; v < 4; v++) begin
            pulse_start(vecs[v].n);
            chk({vecs[v].name, "_busy"}, 64'(busy), 64'd1);
            for (int i = 0; i < vecs[v].n; i++)
                send(vecs[v].xs[i], vecs[v].ys[i], vecs[v].ss[i], vecs[v].cs[i]);
            wait_done({vecs[v].name, "_done"});
            chk_results(vecs[v].name, vecs[v].n, vecs[v].e_err, vecs[v].e_sum,
                        vecs[v].e_max, vecs[v].e_zero, vecs[v].e_co);
        end

        // backpressure / limit: valid pattern 1,0,1,1,0,1 then held high
        begin
            logic [5:0] pat;
            int hs_cnt, cyc, last_hs, done_cyc;
            pat = 6'b101101;   // bit i = cycle i
            hs_cnt = 0; last_hs = -1; done_cyc = -1;
            pulse_start(4);
            s_x = 16'h0010; s_y = 16'h0020; s_sum = 16'h0031; s_cout = 1'b0;
            for (cyc = 0; cyc < 20; cyc++) begin
                s_valid = (cyc < 6) ? pat[cyc] : 1'b1;
                if (s_valid && s_ready) begin
                    hs_cnt++;
                    last_hs = cyc + 1;
                end
                @(negedge clk);
                if (done && done_cyc < 0) done_cyc = cyc + 1;
            end
            chk("bp_handshakes",  64'(hs_cnt), 64'd4);
            chk("bp_ready_after", 64'(s_ready), 64'd0);
            chk("bp_done_delay",  64'(done_cyc - last_hs), 64'd3);
            s_valid = 1'b0;
            chk_results("bp", 4, 4, 64'd4, 1, 0, 0);
        end

        // zero-length run completes the next cycle with cleared results
        pulse_start(0);
        chk("zero_run_done", 64'(done), 64'd1);
        chk("zero_run_busy", 64'(busy), 64'd0);
        chk_results("zero_run", 0, 0, 64'd0, 0, 0, 0);

        // reset in the middle of a run
        pulse_start(5);
        send(16'h0001, 16'h0001, 16'h0003, 1'b0);
        send(16'h0002, 16'h0002, 16'h0004, 1'b0);
        repeat (2) @(negedge clk);
        chk("midrst_pre_count", 64'(sample_count), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy",    64'(busy),    64'd0);
        chk("midrst_done",    64'(done),    64'd0);
        chk("midrst_s_ready", 64'(s_ready), 64'd0);
        chk_results("midrst", 0, 0, 64'd0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("midrst_drained", 64'(sample_count), 64'd0);

        // start pulsed during RUN must not retarget or clear
        pulse_start(2);
        send(16'h0100, 16'h0100, 16'h0202, 1'b0);
        pulse_start(7);
        chk("ign_start_busy", 64'(busy), 64'd1);
        send(16'h0003, 16'h0004, 16'h0007, 1'b0);
        wait_done("ign_start_done");
        chk_results("ign_start", 2, 1, 64'd2, 2, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/approx_adder_error_monitor.md
Name: approx_adder_error_monitor

Overview:
- Synthesizable on-chip checker at the output side of an approximate adder under test (e.g. ETAI, HOERAA).
- Accepts a stream of operand/approximate-result samples over a valid/ready interface and computes the exact sum internally.
- Accumulates error count, total error distance, max error distance, zero-exact-sum count and sample count.
- Software or a bench derives ER, MED, MRED denominators and NMED from the count outputs.

Parameters:
- N, 16, adder operand/result width
- CNT_W, 32, width of sample/error counters
- ACC_W, 48, width of the error-distance accumulator

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle pulse; begins a measurement run
- num_samples  input  CNT_W  samples to accept in the run; sampled on start
- s_valid  input  1  sample valid
- s_ready  output  1  monitor ready to accept a sample
- s_x  input  N  operand X
- s_y  input  N  operand Y
- s_sum  input  N  approximate sum from the adder under test
- s_cout  input  1  approximate carry-out from the adder under test
- busy  output  1  high in RUN and DRAIN
- done  output  1  high in DONE
- sample_count  output  CNT_W  samples processed
- err_count  output  CNT_W  samples with s_sum != exact sum
- sum_ed  output  ACC_W  sum of error distances, saturating
- max_ed  output  N  maximum error distance seen
- zero_count  output  CNT_W  samples whose exact N-bit sum is 0 (MRED excluded)

Behaviour:
- Clock/reset: clk only; reset is synchronous and active-high on rst.
- Reset: state IDLE; s_ready=0, busy=0, done=0; all counters, sum_ed and max_ed = 0; pipeline valids cleared.
- Reset mid-run aborts the run: all state is cleared the same cycle, and in-flight samples are discarded.
- State IDLE:
  - start with num_samples!=0 -> RUN; latch target, clear accumulators.
  - start with num_samples==0 -> DONE next cycle, all results 0.
- State RUN:
  - s_ready=1 while accepted<target.
  - A handshake occurs when s_valid&s_ready; accepted increments.
  - On the handshake of the last sample, s_ready drops the next cycle -> DRAIN.
- State DRAIN: s_ready=0; wait until both pipeline stages are empty -> DONE.
- State DONE:
  - done=1; results held stable.
  - start -> behaves as start from IDLE: clear, then RUN or DONE.
- start while busy is ignored.
- Pipeline, 2 stages:
  - Stage 1 registers x, y, sum, cout.
  - Stage 2 computes exact = (x+y) mod 2^N and ed = |sum - exact| as N-bit unsigned magnitude, then updates the accumulators.
  - Outputs reflect a sample exactly 2 cycles after its handshake.
- Accumulator updates:
  - sample_count+=1.
  - err_count+=(ed!=0).
  - sum_ed+=ed, saturating at 2^ACC_W-1.
  - max_ed=max(max_ed,ed).
  - zero_count+=(exact==0).
- Counters cannot exceed num_samples and need no saturation.
- Carry-out is ignored in the base build.
- s_x/s_y/s_sum are don't-care when no handshake occurs.

Optional Feature:
- Macro: APPROX_MON_COUT_CHECK_EN.
- Defined:
  - Adds output co_err_count (CNT_W, reset 0).
  - It increments in stage 2 when s_cout != exact carry bit (x+y)[N].
  - It is cleared on start like the other counters.
- Undefined: port absent; s_cout unused.

Test Plan:
- Reset check: assert rst 2 cycles -> all outputs 0, s_ready=0, busy=0, done=0.
- Exact sample: start, num_samples=1; x=0x00FF, y=0x0001, sum=0x0100 -> sample_count=1, err_count=0, sum_ed=0, max_ed=0, zero_count=0, done=1.
- Mixed 3 samples:
  - Inputs: (0x1000,0x0234,0x1230), (0xFFFF,0x0001,0x0000), (0x0010,0x0010,0x0025).
  - Expected: err_count=2, sum_ed=9, max_ed=5, zero_count=1.
- Wrap-around: x=0x8000, y=0x8000, sum=0xFFFF -> exact=0, ed=0xFFFF, max_ed=0xFFFF, zero_count=1. With APPROX_MON_COUT_CHECK_EN and s_cout=0 -> co_err_count=1.
- Backpressure/limit:
  - Run with num_samples=4, s_valid toggling 1,0,1,1,0,1, then held high.
  - Expected: exactly 4 handshakes, s_ready low afterward, extra valids ignored, done 3 cycles after the last handshake.
- Boundaries:
  - start with num_samples=0 -> done=1 next cycle, all results 0.
  - rst asserted mid-RUN after 2 samples -> all outputs 0, IDLE next cycle.
  - start pulsed in RUN has no effect.
